food_placer: RTL and testbench
==============================

# food_placer

Consumer end of the random-number path in the Snake game. It takes raw samples from two free-running `lfsr` instances, one for X and one for Y, and turns them into a legal food cell on the 160×120 play grid. It rejects samples that fall off the grid or land on a snake-occupied cell by querying the snake body store. After repeated rejections it falls back to a deterministic wrap-around scan. The result feeds the game-control FSM and the VGA renderer.

## Interface
- `H_CELLS`, 160: grid width in cells.
- `V_CELLS`, 120: grid height in cells.
- `X_BITS`, 8: width of X coordinates and of `RAND_X`.
- `Y_BITS`, 7: width of Y coordinates and of `RAND_Y`.
- `MAX_TRIES`, 16: random attempts allowed before switching to scan mode.
- `RESET_X`, 80 / `RESET_Y`, 60: food position after reset.

- `CLK` input 1: system clock; one clock domain.
- `RESET` input 1: synchronous, active-high reset.
- `REQ` input 1: request a new food cell, level-sampled; ignored while `BUSY`.
- `RAND_X` input X_BITS: X LFSR output; changes every cycle.
- `RAND_Y` input Y_BITS: Y LFSR output; changes every cycle.
- `QUERY_X` output X_BITS: registered cell address sent to the occupancy store.
- `QUERY_Y` output Y_BITS: as above, Y coordinate.
- `OCCUPIED` input 1: occupancy store's answer for `QUERY_X`/`QUERY_Y`; must be valid one cycle after the address changes.
- `TARGET_X` output X_BITS: current food X.
- `TARGET_Y` output Y_BITS: current food Y.
- `VALID` output 1: `TARGET_X`/`TARGET_Y` hold a legal food cell.
- `BUSY` output 1: placement in progress.
- `DONE` output 1: one-cycle pulse when a new target is loaded.
- `FULL` output 1: sticky flag; no free cell exists.

## Operation
- States: IDLE, SAMPLE, QUERY, WAIT, SCAN.
- IDLE
  - `REQ` = 1 → SAMPLE.
  - Effects: `BUSY` = 1, `VALID` = 0, `FULL` = 0, try counter = 0.
- SAMPLE
  - Latch `RAND_X`/`RAND_Y` into the candidate.
  - Candidate in range (X < H_CELLS and Y < V_CELLS) → QUERY.
  - Candidate out of range → increment the try counter; stay in SAMPLE, or go to SCAN once the counter reaches MAX_TRIES.
  - In scan mode, SCAN starts from the last latched candidate, with each coordinate first reduced mod grid size.
- QUERY
  - Register the candidate onto `QUERY_X`/`QUERY_Y`, then → WAIT.
- WAIT
  - Sample `OCCUPIED`.
  - Free cell → load `TARGET`, `VALID` = 1, `BUSY` = 0, pulse `DONE`, → IDLE.
  - Occupied in random mode → increment the try counter; go to SAMPLE, or to SCAN once the counter reaches MAX_TRIES.
  - Occupied in scan mode → SCAN.
- SCAN
  - Increment X; if X reaches H_CELLS, set X = 0 and increment Y; if Y reaches V_CELLS, set Y = 0.
  - Increment the scan counter, then → QUERY.
  - When the scan counter reaches H_CELLS·V_CELLS, the whole grid is occupied: set `FULL` = 1, keep `VALID` = 0, `BUSY` = 0, no `DONE`, → IDLE.
- Arithmetic
  - Range compares are unsigned.
  - The scan counter is 15 bits (must hold 19200).
  - The try counter is clog2(MAX_TRIES)+1 bits.
- `REQ` while `BUSY` is dropped, not queued.
- `REQ` held high across completion starts a new placement on the cycle after `DONE`.

## Timing
- Reset values:
  - `TARGET_X` = RESET_X, `TARGET_Y` = RESET_Y.
  - `VALID` = 1; `BUSY`, `DONE`, `FULL` = 0.
  - `QUERY_X`/`QUERY_Y` = 0; state = IDLE; counters = 0.
- Reset mid-placement aborts immediately and restores the reset values; no `DONE`.
- Latency, counted from the edge that samples `REQ` in IDLE (edge k):
  - SAMPLE at k+1, QUERY at k+2, WAIT at k+3.
  - Best case: `VALID`/`DONE` high after edge k+4.
  - Each extra random attempt costs 3 cycles.
  - Each out-of-range sample costs 1 cycle.
  - Each scan step costs 3 cycles.
- `TARGET_X`/`TARGET_Y` change only on the `DONE` edge and are stable otherwise.
- `QUERY_X`/`QUERY_Y` are stable for the whole WAIT cycle.

## Structure
- Shared package `snake_pkg` holds:
  - grid constants `H_CELLS`, `V_CELLS`, `X_BITS`, `Y_BITS`;
  - the `food_state_t` state encoding.
- Sub-module `grid_step`: combinational (x, y) → (x', y') wrap-around raster increment.
  - Reused later by the renderer's cell walk.
- Top level: one FSM, the two counters, and registered outputs.

## Test plan
- Reset, then `REQ` with `RAND` = (10, 20) and `OCCUPIED` = 0 → `TARGET` = (10, 20), `DONE` after edge k+4; reset values checked first, including (80, 60).
- `RAND` = 200 for 3 cycles, then (5, 5), free → `TARGET` = (5, 5); latency is 3 cycles longer than best case.
- `OCCUPIED` = 1 for the first 16 candidates, last candidate (159, 7); (0, 8) free → scan visits (0, 8) → `TARGET` = (0, 8).
- Scan starting at (159, 119) with that cell occupied → next `QUERY` = (0, 0).
- `OCCUPIED` tied high → after 16 tries plus 19200 scan steps, `FULL` = 1, `VALID` = 0, no `DONE`.
- `RESET` asserted in WAIT → next cycle shows reset values; a `REQ` pulse while `BUSY` has no effect.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared Snake grid constants, food placer state encoding and coordinate wrap helpers.
// Coordinates are unsigned; the wrap helpers fold raw LFSR samples back onto the grid.
package snake_pkg;

    localparam int H_CELLS    = 160;
    localparam int V_CELLS    = 120;
    localparam int X_BITS     = 8;
    localparam int Y_BITS     = 7;
    localparam int GRID_CELLS = H_CELLS * V_CELLS;
    localparam int SCAN_BITS  = 15;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        QUERY,
        WAIT,
        SCAN
    } food_state_t;

    // Raw samples are at most one grid width above range, so one subtraction is a full modulo
    function automatic logic [X_BITS-1:0] wrap_x(input logic [X_BITS-1:0] x);
        return (x >= X_BITS'(H_CELLS)) ? x - X_BITS'(H_CELLS) : x;
    endfunction

    function automatic logic [Y_BITS-1:0] wrap_y(input logic [Y_BITS-1:0] y);
        return (y >= Y_BITS'(V_CELLS)) ? y - Y_BITS'(V_CELLS) : y;
    endfunction

endpackage

// File: rtl/grid_step.sv
// Combinational raster increment over the play grid: X first, wrapping into Y, wrapping to (0, 0).
// Inputs are expected to already lie on the grid.
module grid_step
    import snake_pkg::*;
(
    input  logic [X_BITS-1:0] x,
    input  logic [Y_BITS-1:0] y,
    output logic [X_BITS-1:0] next_x,
    output logic [Y_BITS-1:0] next_y
);

    always_comb begin
        next_x = x + 1'b1;
        next_y = y;
        if (x == X_BITS'(H_CELLS - 1)) begin
            next_x = '0;
            next_y = (y == Y_BITS'(V_CELLS - 1)) ? '0 : y + 1'b1;
        end
    end

endmodule

// File: rtl/food_placer.sv
// Turns free-running LFSR samples into a legal, unoccupied food cell, falling back to a
// raster scan after repeated rejections and flagging FULL when no free cell remains.
module food_placer
    import snake_pkg::*;
#(
    parameter int MAX_TRIES = 16,
    parameter int RESET_X   = 80,
    parameter int RESET_Y   = 60
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic [X_BITS-1:0] RAND_X,
    input  logic [Y_BITS-1:0] RAND_Y,
    output logic [X_BITS-1:0] QUERY_X,
    output logic [Y_BITS-1:0] QUERY_Y,
    input  logic              OCCUPIED,
    output logic [X_BITS-1:0] TARGET_X,
    output logic [Y_BITS-1:0] TARGET_Y,
    output logic              VALID,
    output logic              BUSY,
    output logic              DONE,
    output logic              FULL
);

    localparam int TRY_BITS = $clog2(MAX_TRIES) + 1;

    food_state_t state, state_nxt;

    logic                 req_q;
    logic [X_BITS-1:0]    cand_x;
    logic [Y_BITS-1:0]    cand_y;
    logic [X_BITS-1:0]    step_x;
    logic [Y_BITS-1:0]    step_y;
    logic [TRY_BITS-1:0]  try_cnt;
    logic [SCAN_BITS-1:0] scan_cnt;
    logic                 scan_mode;

    logic rand_in_range;
    logic try_last;
    logic start;
    logic try_inc;
    logic go_scan;
    logic load_target;
    logic set_full;

    assign rand_in_range = (RAND_X < X_BITS'(H_CELLS)) && (RAND_Y < Y_BITS'(V_CELLS));
    assign try_last      = (try_cnt == TRY_BITS'(MAX_TRIES - 1));

    grid_step u_grid_step (
        .x      (wrap_x(cand_x)),
        .y      (wrap_y(cand_y)),
        .next_x (step_x),
        .next_y (step_y)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        try_inc     = 1'b0;
        go_scan     = 1'b0;
        load_target = 1'b0;
        set_full    = 1'b0;
        case (state)
            IDLE: begin
                if (req_q) begin
                    state_nxt = SAMPLE;
                    start     = 1'b1;
                end
            end
            SAMPLE: begin
                if (rand_in_range) begin
                    state_nxt = QUERY;
                end else begin
                    try_inc = 1'b1;
                    if (try_last) begin
                        state_nxt = SCAN;
                        go_scan   = 1'b1;
                    end
                end
            end
            QUERY: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (!OCCUPIED) begin
                    state_nxt   = IDLE;
                    load_target = 1'b1;
                end else if (scan_mode) begin
                    state_nxt = SCAN;
                end else begin
                    try_inc = 1'b1;
                    if (try_last) begin
                        state_nxt = SCAN;
                        go_scan   = 1'b1;
                    end else begin
                        state_nxt = SAMPLE;
                    end
                end
            end
            SCAN: begin
                if (scan_cnt == SCAN_BITS'(GRID_CELLS)) begin
                    state_nxt = IDLE;
                    set_full  = 1'b1;
                end else begin
                    state_nxt = QUERY;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // REQ passes through one register, and only while idle, so requests during a placement are dropped
    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_q     <= 1'b0;
            cand_x    <= '0;
            cand_y    <= '0;
            try_cnt   <= '0;
            scan_cnt  <= '0;
            scan_mode <= 1'b0;
            QUERY_X   <= '0;
            QUERY_Y   <= '0;
            TARGET_X  <= X_BITS'(RESET_X);
            TARGET_Y  <= Y_BITS'(RESET_Y);
            VALID     <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            FULL      <= 1'b0;
        end else begin
            req_q <= REQ && (state == IDLE) && !req_q;
            DONE  <= load_target;
            if (start) begin
                BUSY      <= 1'b1;
                VALID     <= 1'b0;
                FULL      <= 1'b0;
                try_cnt   <= '0;
                scan_cnt  <= '0;
                scan_mode <= 1'b0;
            end
            if (state == SAMPLE) begin
                cand_x <= RAND_X;
                cand_y <= RAND_Y;
            end
            if (try_inc) begin
                try_cnt <= try_cnt + 1'b1;
            end
            if (go_scan) begin
                scan_mode <= 1'b1;
            end
            if (state == QUERY) begin
                QUERY_X <= cand_x;
                QUERY_Y <= cand_y;
            end
            if (state == SCAN && !set_full) begin
                cand_x   <= step_x;
                cand_y   <= step_y;
                scan_cnt <= scan_cnt + 1'b1;
            end
            // The target is taken from the address the store just confirmed free
            if (load_target) begin
                TARGET_X <= QUERY_X;
                TARGET_Y <= QUERY_Y;
                VALID    <= 1'b1;
                BUSY     <= 1'b0;
            end
            if (set_full) begin
                FULL <= 1'b1;
                BUSY <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: directed placements with a queued scoreboard checked on every DONE,
// plus direct checks of reset, abort, dropped requests and the full-grid outcome.
module tb_food_placer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ = 1'b0;
    logic [7:0] RAND_X = '0;
    logic [6:0] RAND_Y = '0;
    logic [7:0] QUERY_X;
    logic [6:0] QUERY_Y;
    logic       OCCUPIED;
    logic [7:0] TARGET_X;
    logic [6:0] TARGET_Y;
    logic       VALID;
    logic       BUSY;
    logic       DONE;
    logic       FULL;

    typedef struct {
        int x;
        int y;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   req_edge = 0;
    int   taken;

    // Occupancy store model: 0 all free, 1 all occupied except one free cell, 2 all occupied
    int         occ_mode = 0;
    logic [7:0] free_x = '0;
    logic [6:0] free_y = '0;

    assign OCCUPIED = (occ_mode == 2) ||
                      (occ_mode == 1 && !(QUERY_X == free_x && QUERY_Y == free_y));

    food_placer dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ      (REQ),
        .RAND_X   (RAND_X),
        .RAND_Y   (RAND_Y),
        .QUERY_X  (QUERY_X),
        .QUERY_Y  (QUERY_Y),
        .OCCUPIED (OCCUPIED),
        .TARGET_X (TARGET_X),
        .TARGET_Y (TARGET_Y),
        .VALID    (VALID),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .FULL     (FULL)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called #1 after an edge; the following edge (k) samples REQ
    task automatic applyStimulus(input logic [7:0] rx, input logic [6:0] ry,
                                 input int ex, input int ey, input int elat);
        exp_t e;
        RAND_X   = rx;
        RAND_Y   = ry;
        REQ      = 1'b1;
        req_edge = cyc + 1;
        if (elat >= 0) begin
            e.x = ex;
            e.y = ey;
            e.lat = elat;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        REQ = 1'b0;
    endtask

    task automatic waitIdle(input int max_cycles, output int lat);
        int n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (BUSY && n < max_cycles);
        if (BUSY) begin
            checkOutput("busy_timeout", 1, 0);
        end
        lat = cyc - req_edge;
    endtask

    // Monitor: every DONE must match the oldest queued expectation
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_done: got DONE with target (%0d,%0d), expected no DONE",
                         TARGET_X, TARGET_Y);
            end else begin
                e = sb.pop_front();
                checkOutput("done_target_x", int'(TARGET_X), e.x);
                checkOutput("done_target_y", int'(TARGET_Y), e.y);
                checkOutput("done_latency", cyc - req_edge, e.lat);
                checkOutput("done_valid", int'(VALID), 1);
                checkOutput("done_busy", int'(BUSY), 0);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        checkOutput("reset_target_x", int'(TARGET_X), 80);
        checkOutput("reset_target_y", int'(TARGET_Y), 60);
        checkOutput("reset_valid", int'(VALID), 1);
        checkOutput("reset_busy", int'(BUSY), 0);
        checkOutput("reset_done", int'(DONE), 0);
        checkOutput("reset_full", int'(FULL), 0);
        checkOutput("reset_query_x", int'(QUERY_X), 0);
        checkOutput("reset_query_y", int'(QUERY_Y), 0);
        @(posedge CLK);
        #1;

        $display("[TB] best case placement");
        occ_mode = 0;
        applyStimulus(8'd10, 7'd20, 10, 20, 4);
        @(posedge CLK);
        #1;
        checkOutput("start_busy", int'(BUSY), 1);
        checkOutput("start_valid", int'(VALID), 0);
        waitIdle(50, taken);
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] three out-of-range samples");
        applyStimulus(8'd200, 7'd5, 5, 5, 7);
        repeat (4) @(posedge CLK);
        #1;
        RAND_X = 8'd5;
        RAND_Y = 7'd5;
        waitIdle(50, taken);
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] sixteen occupied tries then scan");
        occ_mode = 1;
        free_x = 8'd0;
        free_y = 7'd8;
        applyStimulus(8'd159, 7'd7, 0, 8, 52);
        waitIdle(200, taken);
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] scan wraps from the last cell");
        free_x = 8'd0;
        free_y = 7'd0;
        applyStimulus(8'd159, 7'd119, 0, 0, 52);
        repeat (48) @(posedge CLK);
        #1;
        checkOutput("last_try_query_x", int'(QUERY_X), 159);
        checkOutput("last_try_query_y", int'(QUERY_Y), 119);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("wrap_query_x", int'(QUERY_X), 0);
        checkOutput("wrap_query_y", int'(QUERY_Y), 0);
        waitIdle(50, taken);
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] scan entered from out-of-range samples");
        occ_mode = 0;
        applyStimulus(8'd200, 7'd125, 41, 5, 20);
        waitIdle(100, taken);
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] request while busy is dropped");
        applyStimulus(8'd30, 7'd40, 30, 40, 4);
        @(posedge CLK);
        #1;
        REQ = 1'b1;
        @(posedge CLK);
        #1;
        REQ = 1'b0;
        waitIdle(50, taken);
        repeat (6) @(posedge CLK);
        #1;
        checkOutput("dropped_req_busy", int'(BUSY), 0);
        checkOutput("dropped_req_target_x", int'(TARGET_X), 30);
        checkOutput("dropped_req_target_y", int'(TARGET_Y), 40);

        $display("[TB] reset during WAIT");
        applyStimulus(8'd50, 7'd60, 0, 0, -1);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("wait_query_x", int'(QUERY_X), 50);
        checkOutput("wait_query_y", int'(QUERY_Y), 60);
        checkOutput("wait_busy", int'(BUSY), 1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        checkOutput("abort_target_x", int'(TARGET_X), 80);
        checkOutput("abort_target_y", int'(TARGET_Y), 60);
        checkOutput("abort_valid", int'(VALID), 1);
        checkOutput("abort_busy", int'(BUSY), 0);
        checkOutput("abort_done", int'(DONE), 0);
        checkOutput("abort_query_x", int'(QUERY_X), 0);
        repeat (3) @(posedge CLK);
        #1;

        $display("[TB] fully occupied grid");
        occ_mode = 2;
        applyStimulus(8'd3, 7'd4, 0, 0, -1);
        waitIdle(60000, taken);
        checkOutput("full_latency", taken, 57650);
        checkOutput("full_flag", int'(FULL), 1);
        checkOutput("full_valid", int'(VALID), 0);
        checkOutput("full_busy", int'(BUSY), 0);
        checkOutput("full_target_x", int'(TARGET_X), 80);
        repeat (3) @(posedge CLK);
        #1;

        $display("[TB] new request clears FULL");
        occ_mode = 0;
        applyStimulus(8'd1, 7'd2, 1, 2, 4);
        @(posedge CLK);
        #1;
        checkOutput("restart_full", int'(FULL), 0);
        checkOutput("restart_busy", int'(BUSY), 1);
        waitIdle(50, taken);
        repeat (3) @(posedge CLK);
        #1;

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
